mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
Multicycle control unit for the 16-bit accumulator MIPS datapath; sits directly upstream of the datapath and drives every datapath control strobe. Moore FSM sequences fetch, decode, execute, memory and writeback from the latched instruction word and the ALU zero flag. R0 is the accumulator; Ri is selected by instruction[11:9].

Parameters:
RETIRE_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-low reset (0 = reset).
Instruction  in  16  latched IR value from the datapath; opcode = [15:12], func = [2:0].
ZeroFlag  in  1  combinational ALU zero flag.
PCWrite  out  1  PC load enable.
IRWrite  out  1  IR load enable.
MemWrite  out  1  memory write strobe.
PCSource  out  2  00 = PC+1, 01 = jump target, 10 = branch target.
IorD  out  1  0 = PC address, 1 = IR[11:0] address.
RegWrite  out  1  register-file write enable.
MemtoReg  out  1  0 = ALUOut, 1 = MDR.
ALUSrcB  out  2  00 = B, 01 = zero-extended imm12, 10 = constant 0.
ALUOp  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A, 101 PASS B.
RegDst  out  1  0 = R0, 1 = IR[11:9].
instr_done  out  1  one-cycle pulse in the final state of each instruction.
state_dbg  out  4  current state encoding.
retire_cnt  out  RETIRE_W  count of completed instructions; wraps modulo 2^RETIRE_W.

Behaviour:
- Reset: while rst=0 at a clock edge, state <= FETCH (0) and retire_cnt <= 0. While rst=0, every strobe (PCWrite, IRWrite, MemWrite, RegWrite) and instr_done is forced to 0. Reset mid-instruction abandons the instruction with no further writes.
- Outputs are Moore (decoded from the state plus the IR fields), except the BR_EVAL PCWrite, which depends on ZeroFlag. Every output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEM_RD=2, LOAD_WB=3, MEM_WR=4, JMP=5, BR_EVAL=6, EXEC_C=7, EXEC_I=8, ALU_WB=9. Codes 10-15 are illegal and go to FETCH.
- FETCH: IorD=0, IRWrite=1, PCWrite=1, PCSource=00. Next state is DECODE.
- DECODE: A/B load from the register file. Next state by opcode:
  - 0000 LOAD -> MEM_RD.
  - 0001 STORE -> MEM_WR.
  - 0010 JUMP -> JMP.
  - 0100 BRZ -> BR_EVAL.
  - 1000 TYPE-C -> EXEC_C, except func=111 (NOP), which goes to FETCH with instr_done=1.
  - 1100 ADDI, 1101 SUBI, 1110 ANDI, 1111 ORI -> EXEC_I.
  - Any other opcode is a NOP: go to FETCH with instr_done=1.
- MEM_RD: IorD=1; MDR captures the read data. Next state is LOAD_WB.
- LOAD_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next state is FETCH.
- MEM_WR: IorD=1, MemWrite=1, instr_done=1. Next state is FETCH.
- JMP: PCWrite=1, PCSource=01, instr_done=1. Next state is FETCH.
- BR_EVAL: ALUSrcB=10, ALUOp=SUB, PCSource=10, PCWrite=ZeroFlag, instr_done=1. Next state is FETCH.
- EXEC_C: ALUSrcB=00, with ALUOp by func:
  - 000 MOVETO: ALUSrcB=10, ALUOp=ADD.
  - 001 MOVEFROM: ALUOp=PASS B.
  - 010 ADD, 011 SUB, 100 AND, 101 OR: ALUOp as named.
  - 110 NOT: ALUOp=NOT A.
  - Next state is ALU_WB.
- EXEC_I: ALUSrcB=01. ALUOp is ADD, SUB, AND or OR for opcodes 1100, 1101, 1110, 1111 respectively. Next state is ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, instr_done=1. RegDst=1 only for TYPE-C func=000; otherwise RegDst=0. Next state is FETCH.
- Instruction is stable from DECODE to the end of the instruction, because IRWrite is asserted only in FETCH.
- Cycle counts including FETCH: LOAD 4, STORE 3, JUMP 3, BRZ 3, ALU/immediate 4, NOP 2.
- retire_cnt increments by 1 on each edge where instr_done=1 and rst=1. All-ones wraps to 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> state_dbg=0, all strobes 0 during reset; first cycle after release has IRWrite=1, PCWrite=1, PCSource=00, IorD=0; retire_cnt=0.
- LOAD then STORE (0x0005, then 0x1006) -> state_dbg sequences 0,1,2,3 and 0,1,4; LOAD_WB has RegWrite=1, MemtoReg=1; MEM_WR has MemWrite=1, IorD=1; retire_cnt=2.
- BRZ 0x4003 with ZeroFlag=1, then again with ZeroFlag=0 -> BR_EVAL shows PCWrite=1, PCSource=10 in the first case; PCWrite=0 in the second; both take 3 cycles.
- TYPE-C: MOVETO R3 (0x8600) -> EXEC_C has ALUSrcB=10, ALUOp=000; ALU_WB has RegDst=1. MOVEFROM (0x8601) -> ALUOp=101, RegDst=0. NOP (0x8007) -> returns to FETCH after DECODE with instr_done=1.
- Immediate and undefined: ANDI 0xE0FF -> EXEC_I has ALUSrcB=01, ALUOp=010, then ALU_WB. Opcode 0x3 (0x3123) -> treated as NOP, 2 cycles, retire_cnt increments.
- Mid-instruction reset and wrap: assert rst=0 during MEM_RD -> next state FETCH with no RegWrite. With RETIRE_W=2, 5 JUMPs -> retire_cnt=1.

Source files
------------

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle Moore control unit for the 16-bit accumulator
// MIPS datapath. Sequences fetch, decode, execute, memory and writeback from
// the latched instruction word, and drives every datapath control strobe.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset (0 = reset)
//   Instruction  latched IR; opcode = [15:12], func = [2:0]
//   ZeroFlag     combinational ALU zero flag (used only in BR_EVAL)
//   PCWrite, IRWrite, MemWrite, RegWrite   datapath write strobes
//   PCSource     00 PC+1, 01 jump target, 10 branch target
//   IorD         0 PC address, 1 IR[11:0] address
//   MemtoReg     0 ALUOut, 1 MDR
//   ALUSrcB      00 B, 01 zero-extended imm12, 10 constant 0
//   ALUOp        000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A, 101 PASS B
//   RegDst       0 R0, 1 IR[11:9]
//   instr_done   one-cycle pulse in the final state of each instruction
//   state_dbg    current state encoding
//   retire_cnt   completed-instruction count, wraps modulo 2^RETIRE_W
module mips_mc_controller #(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         Instruction,
  input  logic                ZeroFlag,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic [1:0]          PCSource,
  output logic                IorD,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic [1:0]          ALUSrcB,
  output logic [2:0]          ALUOp,
  output logic                RegDst,
  output logic                instr_done,
  output logic [3:0]          state_dbg,
  output logic [RETIRE_W-1:0] retire_cnt
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_RD  = 4'd2,
    LOAD_WB = 4'd3,
    MEM_WR  = 4'd4,
    JMP     = 4'd5,
    BR_EVAL = 4'd6,
    EXEC_C  = 4'd7,
    EXEC_I  = 4'd8,
    ALU_WB  = 4'd9
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_TYPEC = 4'b1000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_NOTA = 3'b100;
  localparam logic [2:0] ALU_PASB = 3'b101;

  localparam logic [2:0] FUNC_MOVETO = 3'b000;
  localparam logic [2:0] FUNC_NOP    = 3'b111;

  state_t     state;
  logic [3:0] opcode;
  logic [2:0] func;
  logic       isImm;
  logic       decodeIsNop;
  logic       pcWriteRaw;
  logic       irWriteRaw;
  logic       memWriteRaw;
  logic       regWriteRaw;
  logic       doneRaw;
  logic       unusedIrBits;

  assign opcode       = Instruction[15:12];
  assign func         = Instruction[2:0];
  assign unusedIrBits = ^Instruction[11:3];

  // Immediate ops share the 11xx opcode prefix; low two bits select the ALU op.
  assign isImm = (opcode[3:2] == 2'b11);

  // Anything that is not a recognised opcode (or TYPE-C func 111) retires in DECODE.
  always_comb begin
    decodeIsNop = 1'b1;
    if (opcode == OP_LOAD || opcode == OP_STORE || opcode == OP_JUMP ||
        opcode == OP_BRZ || isImm)
      decodeIsNop = 1'b0;
    else if (opcode == OP_TYPEC && func != FUNC_NOP)
      decodeIsNop = 1'b0;
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FETCH;
      retire_cnt <= '0;
    end else begin
      if (instr_done)
        retire_cnt <= retire_cnt + RETIRE_W'(1);
      case (state)
        FETCH:   state <= DECODE;
        DECODE: begin
          if (decodeIsNop)               state <= FETCH;
          else if (opcode == OP_LOAD)    state <= MEM_RD;
          else if (opcode == OP_STORE)   state <= MEM_WR;
          else if (opcode == OP_JUMP)    state <= JMP;
          else if (opcode == OP_BRZ)     state <= BR_EVAL;
          else if (opcode == OP_TYPEC)   state <= EXEC_C;
          else                           state <= EXEC_I;
        end
        MEM_RD:  state <= LOAD_WB;
        EXEC_C:  state <= ALU_WB;
        EXEC_I:  state <= ALU_WB;
        default: state <= FETCH;
      endcase
    end
  end

  // Moore output decode from state and IR fields; BR_EVAL PCWrite follows ZeroFlag.
  always_comb begin
    pcWriteRaw  = 1'b0;
    irWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    doneRaw     = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    RegDst      = 1'b0;
    case (state)
      FETCH: begin
        irWriteRaw = 1'b1;
        pcWriteRaw = 1'b1;
      end
      DECODE: doneRaw = decodeIsNop;
      MEM_RD: IorD = 1'b1;
      LOAD_WB: begin
        regWriteRaw = 1'b1;
        MemtoReg    = 1'b1;
        doneRaw     = 1'b1;
      end
      MEM_WR: begin
        IorD        = 1'b1;
        memWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      JMP: begin
        pcWriteRaw = 1'b1;
        PCSource   = 2'b01;
        doneRaw    = 1'b1;
      end
      BR_EVAL: begin
        ALUSrcB    = 2'b10;
        ALUOp      = ALU_SUB;
        PCSource   = 2'b10;
        pcWriteRaw = ZeroFlag;
        doneRaw    = 1'b1;
      end
      EXEC_C: begin
        case (func)
          3'b000: begin
            ALUSrcB = 2'b10;
            ALUOp   = ALU_ADD;
          end
          3'b001:  ALUOp = ALU_PASB;
          3'b010:  ALUOp = ALU_ADD;
          3'b011:  ALUOp = ALU_SUB;
          3'b100:  ALUOp = ALU_AND;
          3'b101:  ALUOp = ALU_OR;
          3'b110:  ALUOp = ALU_NOTA;
          default: ALUOp = ALU_ADD;
        endcase
      end
      EXEC_I: begin
        ALUSrcB = 2'b01;
        case (opcode[1:0])
          2'b00:   ALUOp = ALU_ADD;
          2'b01:   ALUOp = ALU_SUB;
          2'b10:   ALUOp = ALU_AND;
          default: ALUOp = ALU_OR;
        endcase
      end
      ALU_WB: begin
        regWriteRaw = 1'b1;
        doneRaw     = 1'b1;
        RegDst      = (opcode == OP_TYPEC) && (func == FUNC_MOVETO);
      end
      default: ;
    endcase
  end

  // Reset holds every write strobe and the retire pulse low.
  assign PCWrite    = rst & pcWriteRaw;
  assign IRWrite    = rst & irWriteRaw;
  assign MemWrite   = rst & memWriteRaw;
  assign RegWrite   = rst & regWriteRaw;
  assign instr_done = rst & doneRaw;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: stimulus pushes the hand-derived
// expected control vector for each cycle; a negedge monitor pops and compares.
// A second instance with RETIRE_W=2 shares all inputs to exercise counter wrap.
module tb_mips_mc_controller;

  logic        clk;
  logic        rst;
  logic [15:0] Instruction;
  logic        ZeroFlag;

  logic        PCWrite, IRWrite, MemWrite, IorD, RegWrite, MemtoReg, RegDst, instr_done;
  logic [1:0]  PCSource, ALUSrcB;
  logic [2:0]  ALUOp;
  logic [3:0]  state_dbg;
  logic [15:0] retire_cnt;

  logic        wPCWrite, wIRWrite, wMemWrite, wIorD, wRegWrite, wMemtoReg, wRegDst, wDone;
  logic [1:0]  wPCSource, wALUSrcB;
  logic [2:0]  wALUOp;
  logic [3:0]  wState;
  logic [1:0]  wRetire;

  mips_mc_controller #(.RETIRE_W(16)) dut (
    .clk(clk), .rst(rst), .Instruction(Instruction), .ZeroFlag(ZeroFlag),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .PCSource(PCSource),
    .IorD(IorD), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegDst(RegDst), .instr_done(instr_done), .state_dbg(state_dbg),
    .retire_cnt(retire_cnt)
  );

  mips_mc_controller #(.RETIRE_W(2)) dutW (
    .clk(clk), .rst(rst), .Instruction(Instruction), .ZeroFlag(ZeroFlag),
    .PCWrite(wPCWrite), .IRWrite(wIRWrite), .MemWrite(wMemWrite), .PCSource(wPCSource),
    .IorD(wIorD), .RegWrite(wRegWrite), .MemtoReg(wMemtoReg), .ALUSrcB(wALUSrcB),
    .ALUOp(wALUOp), .RegDst(wRegDst), .instr_done(wDone), .state_dbg(wState),
    .retire_cnt(wRetire)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw;
    logic        irw;
    logic        memw;
    logic [1:0]  pcs;
    logic        iord;
    logic        regw;
    logic        m2r;
    logic [1:0]  srcb;
    logic [2:0]  aluop;
    logic        regdst;
    logic        done;
    logic [15:0] rc;
    logic [1:0]  rcW;
  } exp_t;

  exp_t        q[$];
  exp_t        expV;
  exp_t        actV;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] expRc = 16'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t ev(input logic [3:0] st, input logic pcw, input logic irw,
                              input logic memw, input logic [1:0] pcs, input logic iord,
                              input logic regw, input logic m2r, input logic [1:0] srcb,
                              input logic [2:0] aluop, input logic regdst, input logic done);
    exp_t e;
    e.st = st; e.pcw = pcw; e.irw = irw; e.memw = memw; e.pcs = pcs; e.iord = iord;
    e.regw = regw; e.m2r = m2r; e.srcb = srcb; e.aluop = aluop; e.regdst = regdst;
    e.done = done; e.rc = 16'd0; e.rcW = 2'd0;
    return e;
  endfunction

  // Queue one cycle's expectation, advance past the edge, track the retire count.
  task automatic cyc(input exp_t e);
    e.rc  = expRc;
    e.rcW = expRc[1:0];
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!rst) expRc = 16'd0;
    else if (e.done) expRc = expRc + 16'd1;
  endtask

  // FETCH then DECODE; the new IR becomes visible in DECODE.
  task automatic fetchDecode(input logic [15:0] ins, input logic nopDone);
    cyc(ev(4'd0, 1, 1, 0, 2'b00, 0, 0, 0, 2'b00, 3'b000, 0, 0));
    Instruction = ins;
    cyc(ev(4'd1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'b000, 0, nopDone));
  endtask

  task automatic typeC(input logic [15:0] ins, input logic [1:0] srcb,
                       input logic [2:0] aluop, input logic regdst);
    fetchDecode(ins, 1'b0);
    cyc(ev(4'd7, 0, 0, 0, 2'b00, 0, 0, 0, srcb, aluop, 0, 0));
    cyc(ev(4'd9, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 3'b000, regdst, 1));
  endtask

  task automatic immOp(input logic [15:0] ins, input logic [2:0] aluop);
    fetchDecode(ins, 1'b0);
    cyc(ev(4'd8, 0, 0, 0, 2'b00, 0, 0, 0, 2'b01, aluop, 0, 0));
    cyc(ev(4'd9, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 3'b000, 0, 1));
  endtask

  task automatic jump();
    fetchDecode(16'h2ABC, 1'b0);
    cyc(ev(4'd5, 1, 0, 0, 2'b01, 0, 0, 0, 2'b00, 3'b000, 0, 1));
  endtask

  // Monitor: every cycle with a queued expectation is compared on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      expV = q.pop_front();
      actV = {state_dbg, PCWrite, IRWrite, MemWrite, PCSource, IorD, RegWrite, MemtoReg,
              ALUSrcB, ALUOp, RegDst, instr_done, retire_cnt, wRetire};
      vectors++;
      if (actV !== expV) begin
        miscompares++;
        $display("FAIL ctl_vec t=%0t st=%0d got=%h exp=%h", $time, expV.st, actV, expV);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b0;
    Instruction = 16'h0000;
    ZeroFlag    = 1'b0;

    // Three reset edges; state 0 and all strobes low while held.
    @(posedge clk);
    #1;
    cyc(ev(4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'b000, 0, 0));
    cyc(ev(4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'b000, 0, 0));
    rst = 1'b1;

    // LOAD 0x0005: 0,1,2,3
    fetchDecode(16'h0005, 1'b0);
    cyc(ev(4'd2, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 3'b000, 0, 0));
    cyc(ev(4'd3, 0, 0, 0, 2'b00, 0, 1, 1, 2'b00, 3'b000, 0, 1));
    // STORE 0x1006: 0,1,4
    fetchDecode(16'h1006, 1'b0);
    cyc(ev(4'd4, 0, 0, 1, 2'b00, 1, 0, 0, 2'b00, 3'b000, 0, 1));

    // BRZ taken then not taken; ZeroFlag held high through FETCH/DECODE too.
    ZeroFlag = 1'b1;
    fetchDecode(16'h4003, 1'b0);
    cyc(ev(4'd6, 1, 0, 0, 2'b10, 0, 0, 0, 2'b10, 3'b001, 0, 1));
    ZeroFlag = 1'b0;
    fetchDecode(16'h4003, 1'b0);
    cyc(ev(4'd6, 0, 0, 0, 2'b10, 0, 0, 0, 2'b10, 3'b001, 0, 1));

    // TYPE-C ops
    typeC(16'h8600, 2'b10, 3'b000, 1'b1);   // MOVETO R3
    typeC(16'h8601, 2'b00, 3'b101, 1'b0);   // MOVEFROM
    typeC(16'h8002, 2'b00, 3'b000, 1'b0);   // ADD
    typeC(16'h8003, 2'b00, 3'b001, 1'b0);   // SUB
    typeC(16'h8004, 2'b00, 3'b010, 1'b0);   // AND
    typeC(16'h8005, 2'b00, 3'b011, 1'b0);   // OR
    typeC(16'h8E06, 2'b00, 3'b100, 1'b0);   // NOT
    fetchDecode(16'h8007, 1'b1);            // TYPE-C NOP

    // Immediates and undefined opcodes
    immOp(16'hE0FF, 3'b010);                // ANDI
    immOp(16'hC001, 3'b000);                // ADDI
    immOp(16'hD001, 3'b001);                // SUBI
    immOp(16'hF001, 3'b011);                // ORI
    fetchDecode(16'h3123, 1'b1);            // opcode 3 -> NOP
    fetchDecode(16'hB000, 1'b1);            // opcode B -> NOP

    // Reset during MEM_RD: strobes low, IorD still decoded, counter cleared.
    fetchDecode(16'h0005, 1'b0);
    rst = 1'b0;
    cyc(ev(4'd2, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 3'b000, 0, 0));
    rst = 1'b1;

    // Five JUMPs: 16-bit count reaches 5, 2-bit count wraps to 1.
    for (int i = 0; i < 5; i++) jump();
    cyc(ev(4'd0, 1, 1, 0, 2'b00, 0, 0, 0, 2'b00, 3'b000, 0, 0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
